// File: rtl/seout_pkg.sv
// seout_pkg: shared defaults and width helpers for the scatter-engine output stage.
//   DEF_*        default parameter values for seout_param / seout_lane_fifo
//   clog2()      ceiling log2 used for pointer and count widths
//   lane_idx_w() lane-index width: clog2(NUM_LANES), never below 1 bit
//   lane_idx_t   lane index type sized for the default lane count
package seout_pkg;

  localparam int unsigned DEF_NUM_LANES    = 8;
  localparam int unsigned DEF_WORD_W       = 64;
  localparam int unsigned DEF_FIFO_DEPTH   = 16;
  localparam int unsigned DEF_STALL_MARGIN = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? clog2(lanes) : 1;
  endfunction

  typedef logic [lane_idx_w(DEF_NUM_LANES)-1:0] lane_idx_t;

endpackage

// File: rtl/seout_lane_fifo.sv
// seout_lane_fifo: one lane's circular buffer for the scatter output stage.
//   clk    system clock (rising edge)
//   rst    asynchronous active-low reset (pointers and count cleared)
//   push   write din this edge; ignored when full (decided on pre-edge count)
//   pop    retire the head entry this edge; ignored when empty
//   din    word to enqueue
//   head   current head entry (valid only while empty=0)
//   count  number of stored entries, 0..FIFO_DEPTH
//   full   count == FIFO_DEPTH
//   empty  count == 0
module seout_lane_fifo
  import seout_pkg::*;
#(
  parameter  int unsigned WORD_W     = DEF_WORD_W,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned PTR_W      = clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // A push into a full lane is dropped even when that lane pops this edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seout_param.sv
// seout_param: scatter-engine output stage. Per-lane FIFOs collect update words,
// a round-robin arbiter serialises them onto one valid/ready output stream.
//   clk               system clock (rising edge)
//   rst               asynchronous active-low reset
//   input_update      packed lane words, lane i at [i*WORD_W +: WORD_W]
//   input_valid       per-lane write strobe
//   output_word       serialised update (holds last value when idle)
//   output_valid      output_word is valid
//   output_ready      downstream accepts output_word this cycle
//   se_stall_request  registered: some lane holds >= FIFO_DEPTH-STALL_MARGIN words
//   overflow          sticky: an update was dropped on a full lane
// Optional (macro SEOUT_PERF_CNT_EN):
//   words_out         saturating count of output transfers
//   words_dropped     saturating count of dropped updates
module seout_param
  import seout_pkg::*;
#(
  parameter int unsigned NUM_LANES    = DEF_NUM_LANES,
  parameter int unsigned WORD_W       = DEF_WORD_W,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned STALL_MARGIN = DEF_STALL_MARGIN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES*WORD_W-1:0] input_update,
  input  logic [NUM_LANES-1:0]        input_valid,
  output logic [WORD_W-1:0]           output_word,
  output logic                        output_valid,
  input  logic                        output_ready,
  output logic                        se_stall_request,
  output logic                        overflow
`ifdef SEOUT_PERF_CNT_EN
  ,
  output logic [31:0]                 words_out,
  output logic [31:0]                 words_dropped
`endif
);

  localparam int unsigned LANE_W      = lane_idx_w(NUM_LANES);
  localparam int unsigned CNT_W       = clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STALL_LEVEL = FIFO_DEPTH - STALL_MARGIN;

  typedef logic [LANE_W-1:0] lane_t;

  logic [WORD_W-1:0]    lane_head  [NUM_LANES];
  logic [CNT_W-1:0]     lane_count [NUM_LANES];
  logic [NUM_LANES-1:0] lane_full;
  logic [NUM_LANES-1:0] lane_empty;
  logic [NUM_LANES-1:0] lane_pop;
  logic [NUM_LANES-1:0] lane_drop;

  lane_t       rr_ptr;
  lane_t       grant;
  lane_t       rr_next;
  int unsigned idx;
  logic        found;
  logic        loadable;
  logic        stall_level_hit;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    seout_lane_fifo #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (input_valid[g]),
      .pop   (lane_pop[g]),
      .din   (input_update[g*WORD_W +: WORD_W]),
      .head  (lane_head[g]),
      .count (lane_count[g]),
      .full  (lane_full[g]),
      .empty (lane_empty[g])
    );
  end

  assign lane_drop = input_valid & lane_full;
  assign loadable  = !output_valid || output_ready;
  assign rr_next   = (grant == lane_t'(NUM_LANES - 1)) ? '0 : grant + 1'b1;

  // Scan lanes starting at the RR pointer; the first non-empty one wins.
  always_comb begin
    idx             = 0;
    found           = 1'b0;
    grant           = '0;
    lane_pop        = '0;
    stall_level_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_LANES;
      if (!found && !lane_empty[lane_t'(idx)]) begin
        found = 1'b1;
        grant = lane_t'(idx);
      end
    end
    lane_pop[grant] = loadable && found;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (lane_count[k] >= CNT_W'(STALL_LEVEL)) stall_level_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_word      <= '0;
      output_valid     <= 1'b0;
      rr_ptr           <= '0;
      se_stall_request <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      if (loadable) begin
        if (found) begin
          output_word  <= lane_head[grant];
          output_valid <= 1'b1;
          rr_ptr       <= rr_next;
        end else begin
          output_valid <= 1'b0;
        end
      end
      se_stall_request <= stall_level_hit;
      if (|lane_drop) overflow <= 1'b1;
    end
  end

`ifdef SEOUT_PERF_CNT_EN
  // One spare bit detects wrap so both counters saturate at all-ones.
  logic [32:0] out_sum;
  logic [32:0] drop_sum;

  always_comb begin
    out_sum  = 33'(words_out) + 33'(output_valid && output_ready);
    drop_sum = 33'(words_dropped) + 33'($countones(lane_drop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_out     <= '0;
      words_dropped <= '0;
    end else begin
      words_out     <= out_sum[32]  ? '1 : out_sum[31:0];
      words_dropped <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_seout_param.sv
module tb_seout_param;

  localparam int NL = 8;
  localparam int W  = 64;
  localparam int D  = 16;
  localparam int M  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NL*W-1:0] input_update = '0;
  logic [NL-1:0]   input_valid = '0;
  logic [W-1:0]    output_word;
  logic            output_valid;
  logic            output_ready = 1'b0;
  logic            se_stall_request;
  logic            overflow;
`ifdef SEOUT_PERF_CNT_EN
  logic [31:0]     words_out;
  logic [31:0]     words_dropped;
`endif

  int errors = 0;
  int checks = 0;

  seout_param #(
    .NUM_LANES    (NL),
    .WORD_W       (W),
    .FIFO_DEPTH   (D),
    .STALL_MARGIN (M)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .input_update     (input_update),
    .input_valid      (input_valid),
    .output_word      (output_word),
    .output_valid     (output_valid),
    .output_ready     (output_ready),
    .se_stall_request (se_stall_request),
    .overflow         (overflow)
`ifdef SEOUT_PERF_CNT_EN
    ,
    .words_out        (words_out),
    .words_dropped    (words_dropped)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] burst_val(int i);
    logic [31:0] v;
    v = (i == 7) ? 32'd2 : 32'(10 - i);
    return {v, v};
  endfunction

  // Behavioural model: one queue per lane, an output slot and a round-robin start lane.
  logic [W-1:0] mq [NL][$];
  logic [W-1:0] m_word  = '0;
  bit           m_valid = 0;
  bit           m_stall = 0;
  bit           m_ovf   = 0;
  int           m_rr    = 0;
  longint       m_wout  = 0;
  longint       m_wdrop = 0;
  bit           m_full_pre [NL];
  bit           m_any_hi, m_load, m_found;
  int           m_l, m_ndrop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NL; i++) mq[i].delete();
      m_word = '0; m_valid = 0; m_stall = 0; m_ovf = 0; m_rr = 0;
      m_wout = 0; m_wdrop = 0;
    end else begin
      m_any_hi = 0;
      for (int i = 0; i < NL; i++) begin
        if (mq[i].size() >= D - M) m_any_hi = 1;
        m_full_pre[i] = (mq[i].size() == D);
      end
      if (m_valid && output_ready) m_wout = m_wout + 1;
      m_load = !m_valid || output_ready;
      if (m_load) begin
        m_found = 0;
        for (int k = 0; k < NL; k++) begin
          m_l = (m_rr + k) % NL;
          if (!m_found && mq[m_l].size() > 0) begin
            m_found = 1;
            m_word  = mq[m_l].pop_front();
            m_rr    = (m_l + 1) % NL;
          end
        end
        m_valid = m_found;
      end
      m_ndrop = 0;
      for (int i = 0; i < NL; i++) begin
        if (input_valid[i]) begin
          if (m_full_pre[i]) begin
            m_ndrop++;
            m_ovf = 1;
          end else begin
            mq[i].push_back(input_update[i*W +: W]);
          end
        end
      end
      m_wdrop = m_wdrop + m_ndrop;
      if (m_wout > 64'hFFFFFFFF)  m_wout  = 64'hFFFFFFFF;
      if (m_wdrop > 64'hFFFFFFFF) m_wdrop = 64'hFFFFFFFF;
      m_stall = m_any_hi;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_valid", 64'(output_valid), 64'(m_valid));
    chk("m_word", output_word, m_word);
    chk("m_stall", 64'(se_stall_request), 64'(m_stall));
    chk("m_overflow", 64'(overflow), 64'(m_ovf));
`ifdef SEOUT_PERF_CNT_EN
    chk("m_words_out", 64'(words_out), m_wout);
    chk("m_words_dropped", 64'(words_dropped), m_wdrop);
`endif
  end

  // Transfer log of what the DUT actually handed downstream.
  logic [W-1:0] xlog [$];
  always @(posedge clk) begin
    if (rst && output_valid && output_ready) xlog.push_back(output_word);
  end

  task automatic clear_inputs();
    input_valid  = '0;
    input_update = '0;
  endtask

  initial begin
`ifdef SEOUT_PERF_CNT_EN
    logic [31:0] drop_a;
`endif
    #1 rst = 1'b0;

    // Reset held with random inputs.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) input_update[i*W +: W] = {$urandom, $urandom};
      input_valid  = NL'($urandom);
      output_ready = 1'($urandom);
      #1;
      chk("rst_valid", 64'(output_valid), 64'd0);
      chk("rst_word", output_word, 64'd0);
      chk("rst_stall", 64'(se_stall_request), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    output_ready = 1'b1;
    @(negedge clk);

    // Burst: all lanes in one cycle, drained in lane order.
    xlog.delete();
    for (int i = 0; i < NL; i++) input_update[i*W +: W] = burst_val(i);
    input_valid = '1;
    @(negedge clk);
    clear_inputs();
    chk("burst_lat_t", 64'(output_valid), 64'd0);
    @(negedge clk);
    chk("burst_lat_t1", 64'(output_valid), 64'd1);
    chk("burst_first", output_word, 64'h0000000A0000000A);
    repeat (9) @(negedge clk);
    chk("burst_count", 64'(xlog.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < xlog.size()) chk("burst_order", xlog[i], burst_val(i));
    end
    chk("burst_idle", 64'(output_valid), 64'd0);

    // Fairness: lanes 2 and 5 every cycle.
    xlog.delete();
    input_update[2*W +: W] = 64'h2;
    input_update[5*W +: W] = 64'h5;
    input_valid = 8'b0010_0100;
    repeat (6) @(negedge clk);
    clear_inputs();
    repeat (12) @(negedge clk);
    chk("fair_count", 64'(xlog.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < xlog.size()) chk("fair_order", xlog[i], (i % 2 == 0) ? 64'h2 : 64'h5);
    end

    // Backpressure: three words on lane 1 with ready low.
    xlog.delete();
    output_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (n < 3) begin
        input_update[1*W +: W] = 64'(11 + n);
        input_valid = 8'b0000_0010;
      end else begin
        clear_inputs();
      end
      @(negedge clk);
      if (n >= 1) begin
        chk("bp_hold_valid", 64'(output_valid), 64'd1);
        chk("bp_hold_word", output_word, 64'd11);
      end
    end
    output_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_count", 64'(xlog.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < xlog.size()) chk("bp_order", xlog[i], 64'(11 + i));
    end

    // Stall/overflow: all lanes continuously, ready low, stall ignored.
    output_ready = 1'b0;
    input_valid  = '1;
    for (int i = 0; i < NL; i++) input_update[i*W +: W] = {$urandom, $urandom};
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("stall_edge", 64'(se_stall_request), 64'(n >= 12));
      chk("overflow_edge", 64'(overflow), 64'(n >= 16));
`ifdef SEOUT_PERF_CNT_EN
      if (n == 16) chk("drop_first", 64'(words_dropped), 64'd7);
      if (n == 17) drop_a = words_dropped;
      if (n == 18) chk("drop_rate", 64'(words_dropped - drop_a), 64'd8);
`endif
      for (int i = 0; i < NL; i++) input_update[i*W +: W] = {$urandom, $urandom};
    end
    clear_inputs();
    output_ready = 1'b1;
    repeat (140) @(negedge clk);
    chk("drain_stall", 64'(se_stall_request), 64'd0);
    chk("drain_valid", 64'(output_valid), 64'd0);
    chk("drain_overflow_sticky", 64'(overflow), 64'd1);

    // Mid-operation reset with data queued.
    output_ready = 1'b0;
    input_update[3*W +: W] = 64'hDEAD_0003;
    input_update[6*W +: W] = 64'hDEAD_0006;
    input_valid = 8'b0100_1000;
    repeat (2) @(negedge clk);
    clear_inputs();
    @(negedge clk);
    chk("pre_rst_valid", 64'(output_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", 64'(output_valid), 64'd0);
    chk("mrst_word", output_word, 64'd0);
    chk("mrst_stall", 64'(se_stall_request), 64'd0);
    chk("mrst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    output_ready = 1'b1;
    xlog.delete();
    repeat (10) @(negedge clk);
    chk("mrst_no_stale", 64'(xlog.size()), 64'd0);
    chk("mrst_idle", 64'(output_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seout_param.md
Name: seout_param

Overview:
- Parametrised scatter-engine output stage.
- Collects update words from NUM_LANES parallel lanes into per-lane FIFOs.
- Serialises them onto one output stream using round-robin arbitration, with a valid/ready handshake on the output.
- Raises se_stall_request to the scatter pipeline before any lane FIFO can overflow; sits between the scatter lanes and the memory-write path.

Parameters:
- NUM_LANES, 8, number of input update lanes (2..16).
- WORD_W, 64, update word width in bits.
- FIFO_DEPTH, 16, entries per lane FIFO; power of two, >= 4.
- STALL_MARGIN, 4, free entries remaining at which stall is requested; 1..FIFO_DEPTH-1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset.
- input_update  input  NUM_LANES*WORD_W  packed lane words; lane i occupies bits [i*WORD_W +: WORD_W].
- input_valid  input  NUM_LANES  per-lane write strobe.
- output_word  output  WORD_W  serialised update.
- output_valid  output  1  output_word is valid.
- output_ready  input  1  downstream accepts the word this cycle.
- se_stall_request  output  1  upstream must stop issuing updates.
- overflow  output  1  sticky flag: an update was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFO pointers and counts are 0.
  - output_valid=0, output_word=0, se_stall_request=0, overflow=0.
  - Round-robin pointer set to lane 0.
- Push:
  - Lane i pushes on a rising edge when input_valid[i]=1.
  - Full is decided on the pre-edge count.
  - A push to a full lane is dropped (even if the same lane pops that cycle) and overflow is set to 1.
  - overflow clears only on reset.
- Pop/arbitration:
  - Output register is loadable when output_valid=0 or output_ready=1.
  - When loadable, the arbiter picks the first non-empty lane at or after the RR pointer (wrapping NUM_LANES-1 -> 0).
  - That lane's head is popped into output_word and output_valid=1.
  - RR pointer moves to granted lane + 1 (mod NUM_LANES).
  - If loadable and all lanes are empty: output_valid goes to 0 and output_word holds its last value.
- Handshake:
  - While output_valid=1 and output_ready=0, output_word and output_valid stay stable.
  - A transfer occurs on a cycle with output_valid=1 and output_ready=1.
- Simultaneous push and pop on the same non-full lane: count unchanged, data order preserved.
- Latency:
  - A word pushed at edge t, with its lane granted, appears with output_valid=1 after edge t+1.
  - Minimum latency is 2 edges; no fall-through.
- Stall:
  - se_stall_request is registered.
  - It is high the cycle after any lane count is >= FIFO_DEPTH-STALL_MARGIN, and low the cycle after all counts drop below that level.
  - Upstream is required to honour it within STALL_MARGIN-1 cycles.
- Throughput: at most one word per cycle out; sustained input above 1 word/cycle fills the FIFOs and raises stall.
- Reset mid-operation: all queued data is discarded and outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro SEOUT_PERF_CNT_EN.
- Defined:
  - Adds output ports words_out (32-bit, increments on each transfer) and words_dropped (32-bit, increments by the number of lanes dropped that cycle).
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Package seout_pkg:
  - default constants for NUM_LANES, WORD_W, FIFO_DEPTH, STALL_MARGIN;
  - function clog2 for pointer/count widths;
  - lane-index typedef width rule ($clog2(NUM_LANES), min 1).
- Sub-module seout_lane_fifo (WORD_W, FIFO_DEPTH):
  - per-lane circular buffer with push, pop, count, full, empty;
  - instantiated NUM_LANES times via generate.
- Round-robin arbiter and output register stay in the top.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> output_valid=0, output_word=0, se_stall_request=0, overflow=0 throughout.
- Burst: one cycle with all 8 lanes valid (lane0=64'h0000000A0000000A ... lane7=64'h0000000200000002), output_ready=1 -> 8 consecutive transfers in lane order 0..7, first after edge t+1, then output_valid=0.
- Fairness: lanes 2 and 5 valid every cycle (lane2=64'h2, lane5=64'h5), output_ready=1 -> output alternates 2,5,2,5 with no lane starved.
- Backpressure: queue 3 words on lane 1, output_ready=0 for 5 cycles -> output_word stays on the first word and output_valid=1; releasing ready drains the 3 words in order.
- Stall/overflow: all lanes valid continuously, output_ready=0, stall ignored -> se_stall_request rises the cycle after counts reach 12; overflow=1 on the first push at count 16; with SEOUT_PERF_CNT_EN, words_dropped=8 per following cycle.
- Mid-operation reset: assert rst=0 while lanes hold data -> outputs cleared immediately; after release no stale word ever appears.
